// File: rtl/sw_reg_write.sv
// Wishbone-slave software register: one 32-bit control word written by the host and driven to fabric.
// Define SW_REG_WRITE_READBACK_EN to return the register value on read hits (otherwise reads return zero).
module sw_reg_write #(
  parameter logic [31:0] C_BASEADDR      = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR      = 32'h0000_FFFF,
  parameter logic [31:0] C_DEFAULT_VALUE = 32'h0000_0000
) (
  input  logic        wbs_clk_i,
  input  logic        wbs_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic [31:0] fabric_data_out
);

  logic [31:0] r_reg;
  logic        r_ack;
  logic        r_err;
  logic [31:0] r_dat;

  logic        w_accept;
  logic        w_hit;
  logic [31:0] w_rd_data;
  logic [31:0] w_reg_next;
  logic        w_ack_next;
  logic        w_err_next;
  logic [31:0] w_dat_next;

  // A new request is only taken once the previous response pulse has gone out.
  assign w_accept = wbs_cyc_i & wbs_stb_i & ~r_ack & ~r_err;
  assign w_hit    = (wbs_adr_i >= C_BASEADDR) && (wbs_adr_i <= C_HIGHADDR);

`ifdef SW_REG_WRITE_READBACK_EN
  assign w_rd_data = r_reg;
`else
  assign w_rd_data = 32'h0000_0000;
`endif

  // Next-state: byte-lane merge on write hits, response pulse and read data selection.
  always_comb begin
    w_reg_next = r_reg;
    w_ack_next = 1'b0;
    w_err_next = 1'b0;
    w_dat_next = 32'h0000_0000;
    if (w_accept) begin
      if (w_hit) begin
        w_ack_next = 1'b1;
        if (wbs_we_i) begin
          for (int n = 0; n < 4; n++) begin
            if (wbs_sel_i[n]) begin
              w_reg_next[8*n +: 8] = wbs_dat_i[8*n +: 8];
            end else begin
              w_reg_next[8*n +: 8] = r_reg[8*n +: 8];
            end
          end
        end else begin
          w_dat_next = w_rd_data;
        end
      end else begin
        w_err_next = 1'b1;
      end
    end else begin
      w_reg_next = r_reg;
    end
  end

  // State registers; reset clears any pending response and restores the default word.
  always_ff @(posedge wbs_clk_i or negedge wbs_rst_i) begin
    if (!wbs_rst_i) begin
      r_reg <= C_DEFAULT_VALUE;
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= 32'h0000_0000;
    end else begin
      r_reg <= w_reg_next;
      r_ack <= w_ack_next;
      r_err <= w_err_next;
      r_dat <= w_dat_next;
    end
  end

  assign wbs_ack_o       = r_ack;
  assign wbs_err_o       = r_err;
  assign wbs_dat_o       = r_dat;
  assign fabric_data_out = r_reg;

endmodule

// File: tb/tb_sw_reg_write.sv
// Directed self-checking bench for sw_reg_write (default parameters).
module tb_sw_reg_write;

  logic        clk;
  logic        rst_n;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic        ack;
  logic        err;
  logic [31:0] fab;

  int n_checks;
  int n_fails;

`ifdef SW_REG_WRITE_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  sw_reg_write dut (
    .wbs_clk_i       (clk),
    .wbs_rst_i       (rst_n),
    .wbs_cyc_i       (cyc),
    .wbs_stb_i       (stb),
    .wbs_we_i        (we),
    .wbs_sel_i       (sel),
    .wbs_adr_i       (adr),
    .wbs_dat_i       (dat_i),
    .wbs_dat_o       (dat_o),
    .wbs_ack_o       (ack),
    .wbs_err_o       (err),
    .fabric_data_out (fab)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input logic [31:0] exp_fab);
    check({tag, " ack"}, {31'd0, ack}, 32'd0);
    check({tag, " err"}, {31'd0, err}, 32'd0);
    check({tag, " dat"}, dat_o, 32'h0000_0000);
    check({tag, " fab"}, fab, exp_fab);
  endtask

  // One single-cycle request followed by an idle cycle.
  task automatic xfer(input string tag, input logic w, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic e_ack, input logic e_err,
                      input logic [31:0] e_fab, input logic [31:0] e_dat);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat_i = d;
    @(posedge clk); #1;
    check({tag, " ack"}, {31'd0, ack}, {31'd0, e_ack});
    check({tag, " err"}, {31'd0, err}, {31'd0, e_err});
    check({tag, " fab"}, fab, e_fab);
    check({tag, " dat"}, dat_o, e_dat);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check_idle({tag, " after"}, e_fab);
  endtask

  initial begin
    logic [31:0] exp_rd;
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'h0; adr = 32'h0000_0000; dat_i = 32'h0000_0000;

    // Reset held with clock running; a request presented during reset must be ignored.
    repeat (2) @(posedge clk);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; dat_i = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check_idle("reset", 32'h0000_0000);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_idle("post-reset idle", 32'h0000_0000);

    // Full-word writes.
    xfer("wr EEEEEEEE", 1'b1, 32'h0000_0000, 4'hF, 32'hEEEE_EEEE, 1'b1, 1'b0, 32'hEEEE_EEEE, 32'h0);
    xfer("wr FFFFEEEE", 1'b1, 32'h0000_0000, 4'hF, 32'hFFFF_EEEE, 1'b1, 1'b0, 32'hFFFF_EEEE, 32'h0);

    // Byte lanes.
    xfer("sel 0011", 1'b1, 32'h0000_0004, 4'h3, 32'h1234_5678, 1'b1, 1'b0, 32'hFFFF_5678, 32'h0);
    xfer("sel 1000", 1'b1, 32'h0000_0100, 4'h8, 32'hAB00_0000, 1'b1, 1'b0, 32'hABFF_5678, 32'h0);
    xfer("sel 0000", 1'b1, 32'h0000_0000, 4'h0, 32'h0000_0000, 1'b1, 1'b0, 32'hABFF_5678, 32'h0);

    // Window boundary.
    xfer("top hit", 1'b1, 32'h0000_FFFF, 4'hF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0001, 32'h0);
    xfer("miss wr", 1'b1, 32'h0001_0000, 4'hF, 32'h0000_0002, 1'b0, 1'b1, 32'h0000_0001, 32'h0);

    // Reads: hit returns value only with readback, miss always errors with zero data.
    exp_rd = READBACK ? 32'h0000_0001 : 32'h0000_0000;
    xfer("rd hit", 1'b0, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, exp_rd);
    xfer("rd miss", 1'b0, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0001, 32'h0);

    // Held strobe: accepted every second cycle.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_0000; sel = 4'hF; dat_i = 32'h0000_00A5;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("held ack %0d", k), {31'd0, ack}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("held err %0d", k), {31'd0, err}, 32'd0);
    end
    check("held fab", fab, 32'h0000_00A5);
    we = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    check("held rd ack", {31'd0, ack}, 32'd1);
    check("held rd dat", dat_o, READBACK ? 32'h0000_00A5 : 32'h0000_0000);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check_idle("held end", 32'h0000_00A5);

    // Reset asserted in the cycle after an accepted write.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0000_0000; sel = 4'hF; dat_i = 32'h5555_5555;
    @(posedge clk); #1;
    check("mid ack before", {31'd0, ack}, 32'd1);
    check("mid fab before", fab, 32'h5555_5555);
    #1;
    rst_n = 1'b0;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    #1;
    check_idle("mid reset", 32'h0000_0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_idle($sformatf("mid release %0d", k), 32'h0000_0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
